riscv_pc: RTL and testbench



---
 rtl/riscv_pc.sv | 60 ++++++
 tb/tb_riscv_pc.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/riscv_pc.sv
// rtl/riscv_pc.sv - RV32I program-counter register (optional RISCV_PC_ALIGN_CHECK_EN adds pcMisaligned)
module riscv_pc #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pcEn,
   input  logic        pcSrc,
   input  logic [31:0] offset,
   output logic [31:0] pcOutput,
`ifdef RISCV_PC_ALIGN_CHECK_EN
   output logic        pcMisaligned,
`endif
   output logic [31:0] pcPlus4
);

   logic [31:0] r_pc;
   logic [31:0] w_seq_pc;
   logic [31:0] w_target_pc;
   logic [31:0] w_step_pc;
   logic [31:0] w_load_pc;

   // Both candidate addresses are always computed; the select is a true mux,
   // so an unknown offset cannot leak into the PC when the sequential path is chosen.
   always_comb begin
      w_seq_pc    = r_pc + 32'd4;
      w_target_pc = r_pc + offset;
      w_step_pc   = pcSrc ? w_target_pc : w_seq_pc;
      w_load_pc   = rst ? RESET_VECTOR : w_step_pc;
   end

   // PC register: reset has priority over enable; disabled cycles hold the value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc <= RESET_VECTOR;
      end else if (pcEn) begin
         r_pc <= w_step_pc;
      end
   end

   assign pcOutput = r_pc;
   assign pcPlus4  = w_seq_pc;

`ifdef RISCV_PC_ALIGN_CHECK_EN
   logic r_misaligned;

   // Alignment flag tracks the value loaded into the PC; trapping is left to later stages.
   always_ff @(posedge clk) begin
      if (rst || pcEn) begin
         r_misaligned <= (w_load_pc[1:0] != 2'b00);
      end
   end

   assign pcMisaligned = r_misaligned;
`else
   logic w_unused_load;
   assign w_unused_load = ^w_load_pc;
`endif

endmodule

// File: tb/tb_riscv_pc.sv
// tb/tb_riscv_pc.sv - self-checking bench for riscv_pc
module tb_riscv_pc;

   logic        clk;
   logic        rst;
   logic        pcEn;
   logic        pcSrc;
   logic [31:0] offset;
   logic [31:0] pcOutput;
   logic [31:0] pcPlus4;
`ifdef RISCV_PC_ALIGN_CHECK_EN
   logic        pcMisaligned;
`endif

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        rst;
      logic        en;
      logic        src;
      logic [31:0] off;
      logic [31:0] pc;
      logic        mis;
   } vec_t;

   vec_t vq[$];

   riscv_pc #(.RESET_VECTOR(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .pcEn        (pcEn),
      .pcSrc       (pcSrc),
      .offset      (offset),
      .pcOutput    (pcOutput),
`ifdef RISCV_PC_ALIGN_CHECK_EN
      .pcMisaligned(pcMisaligned),
`endif
      .pcPlus4     (pcPlus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic s, input logic [31:0] o);
      @(negedge clk);
      rst    = r;
      pcEn   = e;
      pcSrc  = s;
      offset = o;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic e, input logic s, input logic [31:0] o,
                      input logic [31:0] p, input logic m);
      vec_t v;
      v.rst = r; v.en = e; v.src = s; v.off = o; v.pc = p; v.mis = m;
      vq.push_back(v);
   endtask

   logic [31:0] m_pc;
   logic        m_mis;
   logic        r_b, e_b, s_b;
   logic [31:0] o_v;

   initial begin
      rst = 1'b0; pcEn = 1'b0; pcSrc = 1'b0; offset = 32'h0;

      // reset then six sequential fetches
      add(1, 0, 0, 32'h0,         32'h0000_0000, 0);
      add(0, 1, 0, 32'h0,         32'h0000_0004, 0);
      add(0, 1, 0, 32'h0,         32'h0000_0008, 0);
      add(0, 1, 0, 32'h0,         32'h0000_000C, 0);
      add(0, 1, 0, 32'h0,         32'h0000_0010, 0);
      add(0, 1, 0, 32'h0,         32'h0000_0014, 0);
      add(0, 1, 0, 32'h0,         32'h0000_0018, 0);
      // forward branch then sequential
      add(0, 1, 1, 32'd32,        32'h0000_0038, 0);
      add(0, 1, 0, 32'h0,         32'h0000_003C, 0);
      // stall with pcSrc toggling and junk offsets
      add(0, 0, 1, 32'hDEAD_BEEF, 32'h0000_003C, 0);
      add(0, 0, 0, 32'h1234_5677, 32'h0000_003C, 0);
      add(0, 0, 1, 32'h8000_0001, 32'h0000_003C, 0);
      add(0, 1, 0, 32'hFFFF_FFFF, 32'h0000_0040, 0);
      // backward branch, jump near top of memory, wrap
      add(0, 1, 1, 32'hFFFF_FFF0, 32'h0000_0030, 0);
      add(0, 1, 1, 32'hFFFF_FFCC, 32'hFFFF_FFFC, 0);
      add(0, 1, 0, 32'h0,         32'h0000_0000, 0);
      add(0, 1, 1, 32'h80,        32'h0000_0080, 0);
      // reset beats enable and branch
      add(1, 1, 1, 32'h100,       32'h0000_0000, 0);
      // misaligned target, held across a stall, then realigned
      add(0, 1, 1, 32'h6,         32'h0000_0006, 1);
      add(0, 0, 1, 32'h3,         32'h0000_0006, 1);
      add(0, 1, 1, 32'h2,         32'h0000_0008, 0);

      foreach (vq[i]) begin
         step(vq[i].rst, vq[i].en, vq[i].src, vq[i].off);
         check32($sformatf("tbl%0d_pc", i), pcOutput, vq[i].pc);
         check32($sformatf("tbl%0d_plus4", i), pcPlus4, vq[i].pc + 32'd4);
`ifdef RISCV_PC_ALIGN_CHECK_EN
         check1($sformatf("tbl%0d_mis", i), pcMisaligned, vq[i].mis);
`endif
      end

      // unknown offset must not disturb the PC when it is not selected
      step(0, 0, 1'bx, 32'hxxxx_xxxx);
      check32("xoff_hold", pcOutput, 32'h0000_0008);
      step(0, 1, 0, 32'hxxxx_xxxx);
      check32("xoff_seq", pcOutput, 32'h0000_000C);
      check32("xoff_plus4", pcPlus4, 32'h0000_0010);

      // randomized run against an arithmetic reference
      step(1, 0, 0, 32'h0);
      m_pc  = 32'h0;
      m_mis = 1'b0;
      for (int n = 0; n < 400; n++) begin
         r_b = ($urandom_range(0, 31) == 0);
         e_b = ($urandom_range(0, 3) != 0);
         s_b = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0: o_v = $urandom;
            1: o_v = {$urandom_range(0, 255), 2'b00};
            2: o_v = 32'h0 - {$urandom_range(0, 255), 2'b00};
            default: o_v = $urandom_range(0, 15);
         endcase
         step(r_b, e_b, s_b, o_v);
         if (r_b) begin
            m_pc  = 32'h0;
            m_mis = 1'b0;
         end else if (e_b) begin
            m_pc  = s_b ? m_pc + o_v : m_pc + 32'd4;
            m_mis = (m_pc % 4) != 0;
         end
         check32($sformatf("rnd%0d_pc", n), pcOutput, m_pc);
         check32($sformatf("rnd%0d_plus4", n), pcPlus4, m_pc + 32'd4);
`ifdef RISCV_PC_ALIGN_CHECK_EN
         check1($sformatf("rnd%0d_mis", n), pcMisaligned, m_mis);
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
